// File: rtl/bt_digit_rx_pkg.sv
// Shared types and constants for the Bluetooth UART digit receiver.
package bt_digit_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  // 27 MHz system clock, 9600 baud line.
  localparam int DEFAULT_CLKS_PER_BIT = 2812;

  // True for the ASCII characters '0' through '9'.
  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/bt_digit_rx_if.sv
// Serial input and decoded-output bundle of the digit receiver.
//
// Handshake: there is no back-pressure. Each *_valid / frame_err strobe is
// high for exactly one clk cycle and the accompanying data (digit, rx_byte)
// is already stable in that cycle and held afterwards until the next strobe.
// byte_valid and frame_err are never high together; digit_valid is only
// ever high together with byte_valid.
interface bt_digit_rx_if;
  import bt_digit_rx_pkg::*;

  logic       rx;
  logic [3:0] digit;
  logic       digit_valid;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  rx_state_e  dbg_state;

  modport master (
    input  rx,
    output digit, digit_valid, rx_byte, byte_valid, frame_err, dbg_state
  );

  modport slave (
    output rx,
    input  digit, digit_valid, rx_byte, byte_valid, frame_err, dbg_state
  );

endinterface

// File: rtl/bt_digit_rx_sync_2ff.sv
// 1-bit two-flop synchronizer; resets to 1 so an idle-high line stays idle.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bt_digit_rx.sv
// UART 8N1 receiver that turns ASCII '0'-'9' into a held 4-bit display digit,
// and also reports every framed byte and stop-bit framing errors.
module bt_digit_rx
  import bt_digit_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input logic           clk,
  input logic           rst,
  bt_digit_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_s;

  logic             half_hit;
  logic             bit_end;
  logic             shift_en;
  logic             load_byte;
  logic             load_digit;
  logic             set_err;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign half_hit = (cnt == CNT_HALF);
  assign bit_end  = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision from the synchronized line and the bit timer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle actions implied by the current state and sample point.
  always_comb begin
    shift_en   = (state == DATA) && bit_end;
    load_byte  = (state == STOP) && bit_end && rx_s;
    load_digit = load_byte && is_ascii_digit(shreg);
    set_err    = (state == STOP) && bit_end && !rx_s;
  end

  // Bit timer: restarts on every state change and at the end of each bit;
  // held at zero while idle so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state != state_nxt) || (state == IDLE) || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if ((state == START) && (state_nxt == DATA)) begin
        bit_idx <= 3'd0;
      end else if (shift_en && (bit_idx != 3'd7)) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // Registered outputs: one-cycle strobes plus held byte and digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_byte     <= 8'h00;
      bus.digit       <= 4'd0;
      bus.byte_valid  <= 1'b0;
      bus.digit_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      bus.byte_valid  <= load_byte;
      bus.digit_valid <= load_digit;
      bus.frame_err   <= set_err;
      if (load_byte)  bus.rx_byte <= shreg;
      if (load_digit) bus.digit   <= shreg[3:0];
    end
  end

  // Debug view of the FSM.
  always_comb begin
    bus.dbg_state = state;
  end

endmodule

// File: doc/bt_digit_rx.md
Name: bt_digit_rx

Overview:
UART 8N1 receiver for the Bluetooth serial module's TX line. It decodes ASCII '0'-'9' into a held 4-bit digit for the downstream 7-segment driver. This replaces the free-running digit counter as the source of the displayed digit. It also exposes every received byte and framing errors for debug LEDs.

Parameters:
CLKS_PER_BIT, 2812, clk cycles per UART bit (27 MHz / 9600 baud); must be >= 8
HALF_BIT, (CLKS_PER_BIT-1)/2, cycles from start-bit falling edge to start-bit mid-sample

Ports:
clk  in  1  system clock, 27 MHz
rst  in  1  asynchronous active-high reset
rx  in  1  raw serial line from Bluetooth module; idle high; asynchronous to clk
digit  out  4  last valid decoded digit, 0-9, held
digit_valid  out  1  one-cycle pulse when digit is updated
rx_byte  out  8  last correctly framed byte, held
byte_valid  out  1  one-cycle pulse when rx_byte is updated
frame_err  out  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - digit=0, rx_byte=0x00.
  - digit_valid=0, byte_valid=0, frame_err=0.
  - Both synchronizer FFs=1.
  - FSM=IDLE; bit counter and bit index=0.
- Reset asserted mid-frame aborts the frame with no pulse.
- Synchronization: rx passes through 2 FFs to give rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- Cycle counter: width $clog2(CLKS_PER_BIT). It clears on every state change.
- FSM states:
  - IDLE: rx_s==0 -> START.
  - START: when cnt==HALF_BIT, sample rx_s.
    - Sample 0 -> DATA, bit_idx=0.
    - Sample 1 (glitch) -> IDLE. No outputs change.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into the shift register LSB-first (shreg <= {rx_s, shreg[7:1]}).
    - If bit_idx==7 -> STOP; otherwise bit_idx+1.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1 -> IDLE. Load rx_byte<=shreg and pulse byte_valid.
    - If shreg is in 0x30..0x39 (inclusive), also load digit<=shreg[3:0] and pulse digit_valid in the same cycle.
    - Sample 0 -> BREAK. Pulse frame_err. rx_byte and digit are unchanged.
  - BREAK: wait for rx_s==1, then -> IDLE. A line held low never re-triggers START.
- Output timing:
  - Pulses are registered. They are high for exactly the one cycle following the sampling edge.
  - digit and rx_byte update on that same edge.
- Sampling points: the stop bit is sampled at its middle and IDLE is re-entered there. A start bit that immediately follows the stop bit (back-to-back frames) is therefore detected.
- Non-digit bytes (CR, LF, letters): byte_valid pulses, digit_valid stays 0, and digit holds its previous value.
- digit is never outside 0-9.
- At most one of byte_valid and frame_err is high in any cycle.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK.
  - ASCII_0=8'h30 and ASCII_9=8'h39.
  - Default CLKS_PER_BIT for 27 MHz / 9600.
- One natural sub-module: sync_2ff, a 1-bit two-flop synchronizer with reset value 1.
  - It is reusable for other asynchronous inputs such as buttons.
- FSM, counter and decode stay in bt_digit_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and drive rx at 16 clk per bit.
1. Assert rst async, no clk edge -> digit=0, rx_byte=0x00, all pulses 0. Hold rx=1 for 500 cycles after release -> no pulses.
2. Send 0x37 ('7') -> exactly one cycle with byte_valid=1 and digit_valid=1. Then rx_byte=0x37 and digit=7, held until the next frame.
3. After step 2, send 0x41 ('A'), then 0x0D -> two byte_valid pulses and zero digit_valid pulses. rx_byte ends at 0x0D; digit stays 7.
4. Drive rx low for 5 cycles, then high -> no pulses, FSM back in IDLE.
5. Send 0x35 with the stop bit low, then hold rx low for 100 cycles -> one frame_err pulse only, digit and rx_byte unchanged. Release rx high, then send '2' -> digit=2.
6. Send '1' then '9' with zero idle gap -> two digit_valid pulses 160 cycles apart, final digit=9.
7. Assert rst during bit 4 of '8', release, then send '3' -> no pulse from the aborted frame, digit=3.
